adder_result_checker: RTL and testbench

- Self-checking response end for the carry-select adder datapath.
- Consumes operand/result tuples (a, b, cin, y, cout) from the adder under test and compares each result against a golden sum.
- Counts vectors and errors, and captures the first mismatch; reports pass/fail once a programmed vector count is reached.
- Sits beside the adder in the bench and on-chip BIST wrappers, opposite the stimulus sweep.

---
 rtl/adder_chk_pkg.sv | 23 ++
 rtl/adder_golden_model.sv | 13 +
 rtl/adder_result_checker.sv | 147 ++++++++++++++
 tb/tb_adder_result_checker.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/adder_chk_pkg.sv
// Shared types and default sizing for the adder result checkers.
// The tuple struct is sized at the default width for tables and monitors.
package adder_chk_pkg;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_NUM_VECTORS = 131072;
  localparam int DEF_CNT_W       = 2 * DEF_WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } chk_state_t;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] a;
    logic [DEF_WIDTH-1:0] b;
    logic                 cin;
    logic [DEF_WIDTH-1:0] y;
    logic                 cout;
  } result_t;

endpackage

// File: rtl/adder_golden_model.sv
// Combinational reference adder: {cout, y} = a + b + cin at WIDTH+1 bits.
module adder_golden_model #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH:0]   sum
);

  assign sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/adder_result_checker.sv
// Compares adder tuples against a golden sum through a 2-stage pipeline,
// counting vectors and errors and capturing the first mismatch.
module adder_result_checker
  import adder_chk_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int NUM_VECTORS = DEF_NUM_VECTORS,
  parameter int CNT_W       = 2 * WIDTH + 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [WIDTH-1:0] dut_y,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic             fail_valid,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic             fail_cin,
  output logic [WIDTH-1:0] fail_y,
  output logic             fail_cout
);

  localparam logic [CNT_W-1:0] NUM_LIMIT = CNT_W'(NUM_VECTORS);

  chk_state_t       state_reg;
  logic [CNT_W-1:0] issue_count_reg;
  logic             s1_valid_reg;
  logic [WIDTH-1:0] s1_a_reg;
  logic [WIDTH-1:0] s1_b_reg;
  logic             s1_cin_reg;
  logic [WIDTH-1:0] s1_y_reg;
  logic             s1_cout_reg;
  logic [CNT_W-1:0] vec_count_reg;
  logic [CNT_W-1:0] err_count_reg;
  logic             fail_valid_reg;
  logic [WIDTH-1:0] fail_a_reg;
  logic [WIDTH-1:0] fail_b_reg;
  logic             fail_cin_reg;
  logic [WIDTH-1:0] fail_y_reg;
  logic             fail_cout_reg;

  logic [WIDTH:0]   expected_sum;
  logic             accept;
  logic             mismatch;

  adder_golden_model #(.WIDTH(WIDTH)) u_golden (
    .a   (s1_a_reg),
    .b   (s1_b_reg),
    .cin (s1_cin_reg),
    .sum (expected_sum)
  );

  assign accept   = in_valid && (state_reg == CHECK) && (issue_count_reg < NUM_LIMIT);
  assign mismatch = {s1_cout_reg, s1_y_reg} != expected_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      issue_count_reg <= '0;
      s1_valid_reg    <= 1'b0;
      s1_a_reg        <= '0;
      s1_b_reg        <= '0;
      s1_cin_reg      <= 1'b0;
      s1_y_reg        <= '0;
      s1_cout_reg     <= 1'b0;
      vec_count_reg   <= '0;
      err_count_reg   <= '0;
      fail_valid_reg  <= 1'b0;
      fail_a_reg      <= '0;
      fail_b_reg      <= '0;
      fail_cin_reg    <= 1'b0;
      fail_y_reg      <= '0;
      fail_cout_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          s1_valid_reg <= 1'b0;
          if (start) begin
            // A new run starts from a clean slate, whether first or repeated.
            state_reg       <= CHECK;
            issue_count_reg <= '0;
            vec_count_reg   <= '0;
            err_count_reg   <= '0;
            fail_valid_reg  <= 1'b0;
            fail_a_reg      <= '0;
            fail_b_reg      <= '0;
            fail_cin_reg    <= 1'b0;
            fail_y_reg      <= '0;
            fail_cout_reg   <= 1'b0;
          end
        end
        CHECK: begin
          s1_valid_reg <= accept;
          if (accept) begin
            issue_count_reg <= issue_count_reg + 1'b1;
            s1_a_reg        <= in_a;
            s1_b_reg        <= in_b;
            s1_cin_reg      <= in_cin;
            s1_y_reg        <= dut_y;
            s1_cout_reg     <= dut_cout;
          end
          if (s1_valid_reg && (vec_count_reg < NUM_LIMIT)) begin
            vec_count_reg <= vec_count_reg + 1'b1;
            if (vec_count_reg + 1'b1 == NUM_LIMIT)
              state_reg <= DONE;
            if (mismatch) begin
              if (err_count_reg != '1)
                err_count_reg <= err_count_reg + 1'b1;
              // Only the first failure is kept; it is the most useful for debug.
              if (!fail_valid_reg) begin
                fail_valid_reg <= 1'b1;
                fail_a_reg     <= s1_a_reg;
                fail_b_reg     <= s1_b_reg;
                fail_cin_reg   <= s1_cin_reg;
                fail_y_reg     <= s1_y_reg;
                fail_cout_reg  <= s1_cout_reg;
              end
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy       = (state_reg == CHECK);
  assign done       = (state_reg == DONE);
  assign pass       = done && (err_count_reg == '0);
  assign vec_count  = vec_count_reg;
  assign err_count  = err_count_reg;
  assign fail_valid = fail_valid_reg;
  assign fail_a     = fail_a_reg;
  assign fail_b     = fail_b_reg;
  assign fail_cin   = fail_cin_reg;
  assign fail_y     = fail_y_reg;
  assign fail_cout  = fail_cout_reg;

endmodule

// File: tb/tb_adder_result_checker.sv
// Directed bench: a 4-vector checker at WIDTH=8 and an exhaustive sweep
// of a WIDTH=4 checker with 512 vectors.
module tb_adder_result_checker;
  import adder_chk_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // 4-vector instance, WIDTH=8
  logic        s_start = 0, s_valid = 0, s_cin = 0, s_cout = 0;
  logic [7:0]  s_a = 0, s_b = 0, s_y = 0;
  logic        s_busy, s_done, s_pass, s_fv, s_fcin, s_fcout;
  logic [17:0] s_vec, s_err;
  logic [7:0]  s_fa, s_fb, s_fy;

  adder_result_checker #(.WIDTH(8), .NUM_VECTORS(4)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .in_valid(s_valid),
    .in_a(s_a), .in_b(s_b), .in_cin(s_cin), .dut_y(s_y), .dut_cout(s_cout),
    .busy(s_busy), .done(s_done), .pass(s_pass),
    .vec_count(s_vec), .err_count(s_err), .fail_valid(s_fv),
    .fail_a(s_fa), .fail_b(s_fb), .fail_cin(s_fcin), .fail_y(s_fy), .fail_cout(s_fcout)
  );

  // sweep instance, WIDTH=4, all a x b x cin
  logic        w_start = 0, w_valid = 0, w_cin = 0, w_cout = 0;
  logic [3:0]  w_a = 0, w_b = 0, w_y = 0;
  logic        w_busy, w_done, w_pass, w_fv, w_fcin, w_fcout;
  logic [9:0]  w_vec, w_err;
  logic [3:0]  w_fa, w_fb, w_fy;

  adder_result_checker #(.WIDTH(4), .NUM_VECTORS(512)) u_sweep (
    .clk(clk), .rst(rst), .start(w_start), .in_valid(w_valid),
    .in_a(w_a), .in_b(w_b), .in_cin(w_cin), .dut_y(w_y), .dut_cout(w_cout),
    .busy(w_busy), .done(w_done), .pass(w_pass),
    .vec_count(w_vec), .err_count(w_err), .fail_valid(w_fv),
    .fail_a(w_fa), .fail_b(w_fb), .fail_cin(w_fcin), .fail_y(w_fy), .fail_cout(w_fcout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one small-instance tuple, held for exactly one edge
  task automatic send_small(input result_t t);
    s_valid = 1'b1;
    s_a = t.a; s_b = t.b; s_cin = t.cin; s_y = t.y; s_cout = t.cout;
    tick();
    s_valid = 1'b0;
    $display("small tuple a=%02h b=%02h cin=%0d y=%02h cout=%0d -> vec=%0d err=%0d",
             t.a, t.b, t.cin, t.y, t.cout, s_vec, s_err);
  endtask

  task automatic send_sweep(input int i, input logic corrupt);
    logic [4:0] s;
    w_valid = 1'b1;
    w_a = i[3:0]; w_b = i[7:4]; w_cin = i[8];
    s = {1'b0, w_a} + {1'b0, w_b} + {4'd0, w_cin};
    w_y = s[3:0] ^ {3'b000, corrupt};
    w_cout = s[4];
    tick();
    w_valid = 1'b0;
  endtask

  initial begin
    // reset state
    rst = 1'b1;
    tick();
    check("rst_busy", 32'(s_busy), 0);
    check("rst_done", 32'(s_done), 0);
    check("rst_pass", 32'(s_pass), 0);
    check("rst_vec", 32'(s_vec), 0);
    check("rst_fv", 32'(s_fv), 0);
    rst = 1'b0;
    tick();

    // four correct tuples
    s_start = 1'b1; tick(); s_start = 1'b0;
    check("start_busy", 32'(s_busy), 1);
    send_small('{a:8'h00, b:8'h00, cin:1'b0, y:8'h00, cout:1'b0});
    check("lat_vec0", 32'(s_vec), 0);
    send_small('{a:8'h01, b:8'h01, cin:1'b1, y:8'h03, cout:1'b0});
    check("lat_vec1", 32'(s_vec), 1);
    send_small('{a:8'h80, b:8'h80, cin:1'b0, y:8'h00, cout:1'b1});
    send_small('{a:8'h7F, b:8'h01, cin:1'b0, y:8'h80, cout:1'b0});
    check("good_notdone", 32'(s_done), 0);
    tick();
    check("good_done", 32'(s_done), 1);
    check("good_busy", 32'(s_busy), 0);
    check("good_vec", 32'(s_vec), 4);
    check("good_err", 32'(s_err), 0);
    check("good_pass", 32'(s_pass), 1);

    // restart from DONE, mismatches, wrap, start ignored mid-CHECK
    s_start = 1'b1; tick(); s_start = 1'b0;
    check("restart_vec", 32'(s_vec), 0);
    check("restart_busy", 32'(s_busy), 1);
    check("restart_done", 32'(s_done), 0);
    send_small('{a:8'h0F, b:8'h01, cin:1'b0, y:8'h11, cout:1'b0});
    send_small('{a:8'hFF, b:8'h01, cin:1'b1, y:8'h01, cout:1'b1});
    check("mm1_err", 32'(s_err), 1);
    check("mm1_fv", 32'(s_fv), 1);
    check("mm1_fa", 32'(s_fa), 32'h0F);
    check("mm1_fy", 32'(s_fy), 32'h11);
    s_start = 1'b1;
    send_small('{a:8'h02, b:8'h02, cin:1'b0, y:8'h05, cout:1'b0});
    s_start = 1'b0;
    check("wrap_ok_err", 32'(s_err), 1);
    check("midstart_vec", 32'(s_vec), 2);
    send_small('{a:8'hFF, b:8'h01, cin:1'b1, y:8'h01, cout:1'b0});
    check("mm2_err", 32'(s_err), 2);
    check("mm2_fa_kept", 32'(s_fa), 32'h0F);
    tick();
    check("cout_err", 32'(s_err), 3);
    check("mm_done", 32'(s_done), 1);
    check("mm_pass", 32'(s_pass), 0);
    check("cap_fb", 32'(s_fb), 32'h01);
    check("cap_fcin", 32'(s_fcin), 0);
    check("cap_fcout", 32'(s_fcout), 0);
    check("cap_fy", 32'(s_fy), 32'h11);
    send_small('{a:8'h01, b:8'h01, cin:1'b0, y:8'hAA, cout:1'b0});
    tick();
    check("done_drop_vec", 32'(s_vec), 4);
    check("done_drop_err", 32'(s_err), 3);

    // IDLE drops tuples, including one coincident with start
    rst = 1'b1; tick(); rst = 1'b0;
    send_small('{a:8'h01, b:8'h01, cin:1'b0, y:8'hAA, cout:1'b0});
    s_start = 1'b1;
    send_small('{a:8'h03, b:8'h03, cin:1'b0, y:8'hBB, cout:1'b1});
    s_start = 1'b0;
    tick(); tick();
    check("idle_vec", 32'(s_vec), 0);
    check("idle_err", 32'(s_err), 0);
    check("idle_fv", 32'(s_fv), 0);
    check("idle_start_busy", 32'(s_busy), 1);

    // sweep instance: async reset mid-CHECK at vec_count=10
    w_start = 1'b1; tick(); w_start = 1'b0;
    for (int i = 0; i < 11; i++) send_sweep(i, i == 3);
    check("pre_rst_vec", 32'(w_vec), 10);
    check("pre_rst_fv", 32'(w_fv), 1);
    #2 rst = 1'b1;
    #1;
    check("async_busy", 32'(w_busy), 0);
    check("async_vec", 32'(w_vec), 0);
    check("async_fv", 32'(w_fv), 0);
    check("async_err", 32'(w_err), 0);
    tick();
    rst = 1'b0;
    tick();

    // exhaustive sweep, then extra bad tuples past the limit
    w_start = 1'b1; tick(); w_start = 1'b0;
    for (int i = 0; i < 512; i++) send_sweep(i, 1'b0);
    check("sweep_notdone", 32'(w_done), 0);
    for (int i = 0; i < 5; i++) send_sweep(i, 1'b1);
    tick();
    $display("sweep complete vec=%0d err=%0d pass=%0d", w_vec, w_err, w_pass);
    check("sweep_vec", 32'(w_vec), 512);
    check("sweep_err", 32'(w_err), 0);
    check("sweep_pass", 32'(w_pass), 1);
    check("sweep_fv", 32'(w_fv), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
